// File: rtl/hash_table_response_queue_if.sv
// hash_table_response_queue_if: request tap, hash-table result and response port bundle
interface hash_table_response_queue_if #(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    logic                    req_valid;
    logic [1:0]              req_op;
    logic [KEY_WIDTH-1:0]    req_key;
    logic                    pipe_en;
    logic                    ht_valid;
    logic [DATA_WIDTH-1:0]   ht_read_data;
    logic                    ht_no_element_found;
    logic                    ht_key_already_present;
    logic                    ht_no_write_space;
    logic                    ht_no_deletion_target;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [KEY_WIDTH-1:0]    rsp_key;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [2:0]              rsp_status;
    logic [$clog2(DEPTH):0]  count;
    logic                    sync_err;

    modport master (
        output req_valid, req_op, req_key, ht_valid, ht_read_data, ht_no_element_found,
               ht_key_already_present, ht_no_write_space, ht_no_deletion_target, rsp_ready,
        input  pipe_en, rsp_valid, rsp_key, rsp_data, rsp_status, count, sync_err
    );
    modport slave (
        input  req_valid, req_op, req_key, ht_valid, ht_read_data, ht_no_element_found,
               ht_key_already_present, ht_no_write_space, ht_no_deletion_target, rsp_ready,
        output pipe_en, rsp_valid, rsp_key, rsp_data, rsp_status, count, sync_err
    );
endinterface

// File: rtl/hash_table_response_queue.sv
// hash_table_response_queue: shadows hash-table requests, builds status-coded responses into a FWFT FIFO
module hash_table_response_queue #(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 3,
    parameter int DEPTH      = 8
) (
    input logic clk,
    input logic reset,
    hash_table_response_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
        logic [2:0]            status;
    } rsp_t;

    logic [LATENCY-1:0]   sh_valid;
    logic [1:0]           sh_op  [LATENCY];
    logic [KEY_WIDTH-1:0] sh_key [LATENCY];
    rsp_t                 mem [DEPTH];
    rsp_t                 new_rsp;
    rsp_t                 head;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 sync_err;
    logic                 pipe_en;
    logic                 push;
    logic                 pop;
    logic                 rsp_valid;
    logic                 tail_valid;
    logic [1:0]           tail_op;

    // Enable depends only on registered count, so a push is always guaranteed a slot
    assign pipe_en    = count < (AW+1)'(DEPTH);
    assign tail_valid = sh_valid[LATENCY-1];
    assign tail_op    = sh_op[LATENCY-1];
    assign push       = pipe_en && tail_valid;
    assign rsp_valid  = count != '0;
    assign pop        = rsp_valid && bus.rsp_ready;
    assign head       = mem[rd_ptr];

    always_comb begin
        new_rsp.key    = sh_key[LATENCY-1];
        new_rsp.data   = (tail_op == 2'b01 && !bus.ht_no_element_found) ? bus.ht_read_data : '0;
        new_rsp.status = tail_op == 2'b01 ? (bus.ht_no_element_found ? 3'd1 : 3'd0) :
                         tail_op == 2'b10 ? (bus.ht_key_already_present ? 3'd3 :
                                             bus.ht_no_write_space ? 3'd4 : 3'd2) :
                                            (bus.ht_no_deletion_target ? 3'd6 : 3'd5);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_valid <= '0;
        end else if (pipe_en) begin
            sh_valid[0] <= bus.req_valid && bus.req_op != 2'b00;
            sh_op[0]    <= bus.req_op;
            sh_key[0]   <= bus.req_key;
            for (int i = 1; i < LATENCY; i++) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_op[i]    <= sh_op[i-1];
                sh_key[i]   <= sh_key[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= new_rsp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sync_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pipe_en && bus.ht_valid != tail_valid)
                sync_err <= 1'b1;
        end
    end

    assign bus.pipe_en    = pipe_en;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_key    = rsp_valid ? head.key : '0;
    assign bus.rsp_data   = rsp_valid ? head.data : '0;
    assign bus.rsp_status = rsp_valid ? head.status : '0;
    assign bus.count      = count;
    assign bus.sync_err   = sync_err;
endmodule
